// File: rtl/msdap_input_loader.sv
// msdap_input_loader: input-side controller of the MSDAP datapath.
// Clears the data memory, then loads rj words, coefficients and a circular
// stream of data samples, pacing the source with a registered readyForData.
// Optional sleep-on-zero-run behaviour is built when MSDAP_SLEEP_EN is defined.
module msdap_input_loader #(
    parameter int RJ_WORDS    = 16,
    parameter int COEFF_WORDS = 512,
    parameter int DATA_DEPTH  = 256,
    parameter int ZERO_RUN    = 800
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] inData,
    input  logic        validData,
    output logic        readyForData,
    output logic        rjWe,
    output logic        coeffWe,
    output logic        dataWe,
    output logic [8:0]  wAddr,
    output logic [15:0] wData,
    output logic        newSample,
    output logic        sleeping,
    output logic [3:0]  status
);
    localparam int PW = $clog2(DATA_DEPTH);

    typedef enum logic [3:0] {
        ST_CLEAR = 4'd0,
        ST_RJ    = 4'd1,
        ST_COEFF = 4'd2,
        ST_DATA  = 4'd3,
        ST_SLEEP = 4'd4
    } state_t;

    state_t        state_q, state_d;
    logic [9:0]    cnt_q, cnt_d;      // clear address / rj index / coeff index
    logic [PW-1:0] ptr_q, ptr_d;      // circular data write pointer
    logic          ready_q, ready_d;
    logic          rj_we_q, rj_we_d;
    logic          coeff_we_q, coeff_we_d;
    logic          data_we_q, data_we_d;
    logic          new_sample_q, new_sample_d;
    logic [8:0]    waddr_q, waddr_d;
    logic [15:0]   wdata_q, wdata_d;
    logic          accept;
    logic          data_wr;

`ifdef MSDAP_SLEEP_EN
    logic [9:0]    zcnt_q, zcnt_d;
    logic [9:0]    zcnt_inc;
    assign zcnt_inc = (zcnt_q == 10'h3FF) ? zcnt_q : zcnt_q + 10'd1;
`endif

    assign accept = validData && ready_q;

    // Next-state, handshake and registered write-port computation.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        ptr_d        = ptr_q;
        ready_d      = ready_q;
        rj_we_d      = 1'b0;
        coeff_we_d   = 1'b0;
        data_we_d    = 1'b0;
        new_sample_d = 1'b0;
        waddr_d      = '0;
        wdata_d      = '0;
        data_wr      = 1'b0;
`ifdef MSDAP_SLEEP_EN
        zcnt_d       = zcnt_q;
`endif
        case (state_q)
            ST_CLEAR: begin
                // One idle step after the last clear write keeps status at 0
                // for the whole clear sweep.
                ready_d = 1'b0;
                if (cnt_q == 10'(DATA_DEPTH)) begin
                    state_d = ST_RJ;
                    cnt_d   = '0;
                    ready_d = 1'b1;
                end else begin
                    data_we_d = 1'b1;
                    waddr_d   = cnt_q[8:0];
                    cnt_d     = cnt_q + 10'd1;
                end
            end
            ST_RJ: if (accept) begin
                rj_we_d = 1'b1;
                waddr_d = cnt_q[8:0];
                wdata_d = inData;
                if (cnt_q == 10'(RJ_WORDS - 1)) begin
                    state_d = ST_COEFF;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 10'd1;
                end
            end
            ST_COEFF: if (accept) begin
                coeff_we_d = 1'b1;
                waddr_d    = cnt_q[8:0];
                wdata_d    = inData;
                if (cnt_q == 10'(COEFF_WORDS - 1)) begin
                    state_d = ST_DATA;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 10'd1;
                end
            end
            ST_DATA: if (accept) begin
                data_wr = 1'b1;
`ifdef MSDAP_SLEEP_EN
                if (inData == 16'd0) begin
                    zcnt_d = zcnt_inc;
                    if (zcnt_inc == 10'(ZERO_RUN)) state_d = ST_SLEEP;
                end else begin
                    zcnt_d = '0;
                end
`endif
            end
`ifdef MSDAP_SLEEP_EN
            ST_SLEEP: if (accept) begin
                // Zeros are swallowed; the first nonzero word wakes us up.
                if (inData == 16'd0) begin
                    zcnt_d = zcnt_inc;
                end else begin
                    data_wr = 1'b1;
                    zcnt_d  = '0;
                    state_d = ST_DATA;
                end
            end
`endif
            default: state_d = ST_CLEAR;
        endcase

        if (data_wr) begin
            data_we_d    = 1'b1;
            new_sample_d = 1'b1;
            waddr_d      = 9'(ptr_q);
            wdata_d      = inData;
            ptr_d        = ptr_q + 1'b1;
        end

        // Ready drops for the cycle after each accepted word.
        if (state_q != ST_CLEAR) ready_d = !accept;
    end

    // State and output registers, cleared asynchronously.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_CLEAR;
            cnt_q        <= '0;
            ptr_q        <= '0;
            ready_q      <= 1'b0;
            rj_we_q      <= 1'b0;
            coeff_we_q   <= 1'b0;
            data_we_q    <= 1'b0;
            new_sample_q <= 1'b0;
            waddr_q      <= '0;
            wdata_q      <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            ptr_q        <= ptr_d;
            ready_q      <= ready_d;
            rj_we_q      <= rj_we_d;
            coeff_we_q   <= coeff_we_d;
            data_we_q    <= data_we_d;
            new_sample_q <= new_sample_d;
            waddr_q      <= waddr_d;
            wdata_q      <= wdata_d;
        end
    end

`ifdef MSDAP_SLEEP_EN
    // Zero-run counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) zcnt_q <= '0;
        else       zcnt_q <= zcnt_d;
    end
    assign sleeping = (state_q == ST_SLEEP);
`else
    assign sleeping = 1'b0;
`endif

    assign readyForData = ready_q;
    assign rjWe         = rj_we_q;
    assign coeffWe      = coeff_we_q;
    assign dataWe       = data_we_q;
    assign newSample    = new_sample_q;
    assign wAddr        = waddr_q;
    assign wData        = wdata_q;
    assign status       = state_q;
endmodule

// File: tb/tb_msdap_input_loader.sv
// Directed self-checking bench for msdap_input_loader.
module tb_msdap_input_loader;
    localparam int K_RJ = 0, K_CF = 1, K_DT = 2, K_DROP = 3;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] inData = '0;
    logic        validData = 1'b0;
    logic        readyForData, rjWe, coeffWe, dataWe, newSample, sleeping;
    logic [8:0]  wAddr;
    logic [15:0] wData;
    logic [3:0]  status;

    int n_chk = 0, n_pass = 0;
    int mon_rj = 0, mon_cf = 0, mon_dwe = 0, mon_ns = 0;
    int exp_rj = 0, exp_cf = 0, exp_dwe = 0, exp_ns = 0;
    int ptr = 0;

    always #5 clk = ~clk;

    msdap_input_loader dut (
        .clk(clk), .reset(reset), .inData(inData), .validData(validData),
        .readyForData(readyForData), .rjWe(rjWe), .coeffWe(coeffWe),
        .dataWe(dataWe), .wAddr(wAddr), .wData(wData), .newSample(newSample),
        .sleeping(sleeping), .status(status)
    );

    // Strobe-cycle counters catch stretched or duplicated write pulses.
    always @(negedge clk) begin
        if (rjWe)      mon_rj  <= mon_rj + 1;
        if (coeffWe)   mon_cf  <= mon_cf + 1;
        if (dataWe)    mon_dwe <= mon_dwe + 1;
        if (newSample) mon_ns  <= mon_ns + 1;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic check_counts(input string tag);
        @(negedge clk); #1;
        chk({tag, "_cnt"}, {16'(mon_rj), 16'(mon_cf), 16'(mon_dwe), 16'(mon_ns)},
            {16'(exp_rj), 16'(exp_cf), 16'(exp_dwe), 16'(exp_ns)});
    endtask

    task automatic check_clear();
        for (int i = 0; i < 256; i++) begin
            @(posedge clk); #1;
            chk("clear", {dataWe, wAddr, wData, readyForData, status, rjWe, coeffWe, newSample},
                {1'b1, 9'(i), 16'h0, 1'b0, 4'd0, 3'b000});
        end
        @(posedge clk); #1;
        chk("clear_done", {dataWe, readyForData, status}, {1'b0, 1'b1, 4'd1});
        exp_dwe += 256;
    endtask

    task automatic send(input logic [15:0] w, input int kind, input logic [8:0] addr, input int gap);
        int t;
        logic [63:0] e;
        t = 0;
        @(negedge clk);
        while (!readyForData && t < 20) begin
            @(negedge clk);
            t++;
        end
        if (!readyForData) chk("ready_timeout", 64'(readyForData), 64'd1);
        for (int g = 0; g < gap; g++) begin
            chk("gap", {readyForData, rjWe, coeffWe, dataWe, newSample}, 5'b10000);
            @(negedge clk);
        end
        inData = w;
        validData = 1'b1;
        @(posedge clk); #1;
        validData = 1'b0;
        inData = 16'($urandom);
        e = {kind == K_RJ, kind == K_CF, kind == K_DT, kind == K_DT, 1'b0,
             (kind == K_DROP) ? 9'd0 : addr, (kind == K_DROP) ? 16'd0 : w};
        chk((kind == K_RJ) ? "rj_wr" : (kind == K_CF) ? "coeff_wr" : (kind == K_DT) ? "data_wr" : "drop",
            {rjWe, coeffWe, dataWe, newSample, readyForData, wAddr, wData}, e);
        if (kind == K_RJ) exp_rj++;
        if (kind == K_CF) exp_cf++;
        if (kind == K_DT) begin exp_dwe++; exp_ns++; end
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("reset", {readyForData, rjWe, coeffWe, dataWe, newSample, sleeping, status, wAddr, wData}, 64'd0);
        @(negedge clk);
        reset = 1'b0;
        check_clear();

        for (int i = 0; i < 16; i++) send(16'(i + 1), K_RJ, 9'(i), 0);
        chk("status_coeff", status, 4'd2);
        for (int i = 0; i < 512; i++) send(16'(16'h100 + i), K_CF, 9'(i), (i % 128 == 64) ? 5 : 0);
        chk("status_data", status, 4'd3);
        check_counts("load");

        for (int i = 0; i < 300; i++) begin
            send(16'(i + 1), K_DT, 9'(ptr % 256), (i == 150 || i == 257) ? 5 : 0);
            ptr++;
        end
        check_counts("data300");

        for (int i = 0; i < 800; i++) begin
            send(16'h0, K_DT, 9'(ptr % 256), 0);
            ptr++;
        end
`ifdef MSDAP_SLEEP_EN
        chk("sleep_on", {sleeping, status}, {1'b1, 4'd4});
        for (int i = 0; i < 10; i++) send(16'h0, K_DROP, 9'd0, 0);
`else
        chk("sleep_on", {sleeping, status}, {1'b0, 4'd3});
        for (int i = 0; i < 10; i++) begin
            send(16'h0, K_DT, 9'(ptr % 256), 0);
            ptr++;
        end
`endif
        send(16'h1234, K_DT, 9'(ptr % 256), 0);
        ptr++;
        chk("wake", {sleeping, status}, {1'b0, 4'd3});
        check_counts("zeros");

        // Second load, aborted by reset in the middle of the coefficients.
        @(negedge clk); reset = 1'b1;
        @(negedge clk); reset = 1'b0;
        check_clear();
        for (int i = 0; i < 16; i++) send(16'(16'h50 + i), K_RJ, 9'(i), 0);
        for (int i = 0; i < 200; i++) send(16'(16'h300 + i), K_CF, 9'(i), 0);
        #5;
        reset = 1'b1;
        #1;
        chk("async_reset", {readyForData, rjWe, coeffWe, dataWe, newSample, sleeping, status, wAddr, wData}, 64'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        check_clear();
        send(16'hABCD, K_RJ, 9'd0, 0);
        chk("restart_rj", status, 4'd1);
        check_counts("restart");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/msdap_input_loader.md
# msdap_input_loader

Input-side controller of the MSDAP datapath. It accepts the 16-bit word stream presented on `inData`/`validData`: 16 rj values, then 512 coefficient words, then an unbounded run of data samples. It produces the `readyForData` handshake that paces the source, and generates registered write strobes/addresses into the rj, coefficient and circular data memories. It also flags each new data sample for the compute engine and tracks long zero runs for sleep mode.

## Interface
- `RJ_WORDS`, 16, number of rj words loaded first
- `COEFF_WORDS`, 512, number of coefficient words loaded second
- `DATA_DEPTH`, 256, data memory depth (power of two; circular)
- `ZERO_RUN`, 800, consecutive zero samples that trigger sleep

- `clk`  in  1  system clock; all logic on rising edge
- `reset`  in  1  one clock; reset is asynchronous and active-high
- `inData`  in  16  word from source
- `validData`  in  1  `inData` valid this cycle
- `readyForData`  out  1  loader can accept a word this cycle
- `rjWe`  out  1  rj memory write strobe
- `coeffWe`  out  1  coefficient memory write strobe
- `dataWe`  out  1  data memory write strobe
- `wAddr`  out  9  write address (rj uses [3:0], data uses [7:0])
- `wData`  out  16  write data
- `newSample`  out  1  one-cycle pulse: a data sample was written
- `sleeping`  out  1  high while in SLEEP
- `status`  out  4  current state code

## Operation
- States and codes: CLEAR=0, RJ=1, COEFF=2, DATA=3, SLEEP=4.
- Transfer: a word is accepted at a rising edge where `validData && readyForData`. `inData` is ignored otherwise.
- CLEAR: entered on reset.
  - Writes 0 to data addresses 0..DATA_DEPTH-1, one per cycle (`dataWe`=1, `wData`=0).
  - `readyForData`=0 and `newSample`=0 throughout.
  - After address DATA_DEPTH-1 is written, goes to RJ.
- RJ: accepts RJ_WORDS words to `rjWe` at addresses 0..15, then goes to COEFF.
- COEFF: accepts COEFF_WORDS words to `coeffWe` at addresses 0..511, then goes to DATA.
  - Bit 8 is the sign and bits 7:0 are the offset; both are passed through unmodified in `wData`.
- DATA: each accepted word is written to `dataWe` at the circular pointer.
  - The pointer increments modulo DATA_DEPTH (255 wraps to 0).
  - `newSample` pulses with `dataWe`.
- Zero counter: 10 bits, saturating.
  - Cleared by any nonzero data word; incremented by each zero data word.
  - Reaching ZERO_RUN enters SLEEP after that word's write completes.
- SLEEP:
  - Zero words are accepted and discarded: no `dataWe`, no `newSample`, pointer held.
  - A nonzero word is written exactly as in DATA, clears the counter, and returns to DATA in the same transfer.
- Only reset leaves DATA/SLEEP. There is no end-of-stream state.
- Reset values: `readyForData`=0, all strobes 0, `wAddr`=0, `wData`=0, `newSample`=0, `sleeping`=0, `status`=0, pointer=0, counters=0.

## Timing
- Write outputs are registered: a word accepted at edge k drives strobe/`wAddr`/`wData`/`newSample` high for exactly the cycle after edge k.
- `readyForData` is registered. It drops for the cycle following every accepted word, so a new rising edge of `readyForData` marks each request. Source gaps (`validData`=0) hold `readyForData` high with no write.
- Peak throughput is one word per 2 cycles.
- CLEAR lasts DATA_DEPTH cycles after reset deassert. `readyForData` first rises on the edge after the last CLEAR write.
- Phase boundaries:
  - The 16th rj word's write cycle is the last `rjWe`.
  - The next accepted word is coefficient 0, written at address 0 with `coeffWe`.
  - The same rule applies from coefficient 511 to data sample 0.
- Reset asserted mid-phase: outputs clear immediately (asynchronously). Re-entry is always CLEAR, then RJ; all prior loads are discarded.
- `status` changes on the same edge as the state register.

## Configuration
- `MSDAP_SLEEP_EN` defined: zero counter and SLEEP state are present as described.
- Not defined:
  - Counter and SLEEP are removed.
  - Every data word, zero or not, is written and pulses `newSample`.
  - `sleeping` is tied 0, and `status` never reads 4.

## Test plan
- Reset for 3 cycles, then release. Required: 256 consecutive `dataWe` cycles with `wData`=0 and addresses 0..255, `readyForData`=0 and `status`=0 throughout. `readyForData`=1 and `status`=1 on the next cycle.
- Source feeds 16 rj words 0x0001..0x0010, then 512 coefficients with `wData`=0x0100+index. Required: `rjWe` at addresses 0..15, `coeffWe` at addresses 0..511, `status` 1→2→3, and the first data word written at data address 0.
- Source feeds 300 nonzero data words. Required: 300 `newSample` pulses, and word 256 written at address 0 (wrap).
- Source inserts 5-cycle `validData` gaps. Required: `readyForData` held high, no strobes, no lost or duplicated words.
- With `MSDAP_SLEEP_EN`, feed 800 zeros, then 10 zeros, then 0x1234. Required: `sleeping`=1 after the 800th zero's write, no `dataWe` for the next 10 zeros, 0x1234 written at the next pointer address, `status`=3. Without the macro, all 811 words are written.
- Assert `reset` during the COEFF phase at word 200. Required: strobes drop immediately and CLEAR restarts. The next accepted word is rj 0 at address 0.
